// File: rtl/csla_acc_seq.sv
// csla_acc_seq -- accumulates a block of 1..16 unsigned 16-bit samples into a
// 20-bit sum, using a single carry-select adder as its only arithmetic unit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request to begin a block (honoured in IDLE, or in DONE with out_ready)
//   len        block length minus one, captured with start
//   abort      synchronous cancel from any state
//   in_valid   sample valid
//   in_data    unsigned 16-bit sample
//   in_ready   block accepts a sample this cycle (ACC)
//   out_valid  out_data holds a finished sum (DONE)
//   out_data   accumulated sum, driven 0 outside DONE
//   out_ready  consumer accepts out_data
//   busy       high in ACC or DONE

// csla -- 16-bit a plus 20-bit b into 20 bits, built from five 4-bit
// carry-select blocks. Each upper block precomputes its sum for both carry-in
// values and the ripple of block carries only drives the selecting muxes.
module csla (
    input  logic [15:0] a,
    input  logic [19:0] b,
    output logic [19:0] sum
);
    logic [19:0] a_ext;
    logic [4:0]  carry;

    assign a_ext    = {4'b0000, a};
    assign carry[0] = 1'b0;

    for (genvar g = 0; g < 5; g++) begin : g_blk
        if (g < 4) begin : g_lo
            logic [4:0] s0;
            logic [4:0] s1;
            assign s0 = {1'b0, a_ext[4*g +: 4]} + {1'b0, b[4*g +: 4]};
            assign s1 = s0 + 5'd1;
            assign sum[4*g +: 4] = carry[g] ? s1[3:0] : s0[3:0];
            assign carry[g+1]    = carry[g] ? s1[4]   : s0[4];
        end else begin : g_top
            // The top nibble's carry-out would be bit 20, which cannot occur
            // for a block of at most 16 samples, so it is not formed.
            logic [3:0] t0;
            logic [3:0] t1;
            assign t0 = a_ext[4*g +: 4] + b[4*g +: 4];
            assign t1 = t0 + 4'd1;
            assign sum[4*g +: 4] = carry[g] ? t1 : t0;
        end
    end
endmodule

module csla_acc_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [19:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [19:0]      acc;
    logic [19:0]      acc_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt;
    logic [19:0]      add_sum;

    csla u_csla (
        .a   (in_data),
        .b   (acc),
        .sum (add_sum)
    );

    // Outputs decode straight from the state register so that an asynchronous
    // reset clears them at once, without waiting for a clock edge.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC) || (state == DONE);
    assign out_data  = (state == DONE) ? acc : 20'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 20'd0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_q;

        // abort outranks both start and a sample presented in the same cycle.
        if (abort) begin
            state_nxt = IDLE;
            acc_nxt   = 20'd0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ACC;
                        len_nxt   = len;
                        acc_nxt   = 20'd0;
                        cnt_nxt   = '0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_nxt = add_sum;
                        // On the final sample the counter is left alone so
                        // that it never wraps at a 16-sample block.
                        if (cnt == len_q) begin
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt = cnt + LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            // Back-to-back block: skip IDLE entirely.
                            state_nxt = ACC;
                            len_nxt   = len;
                            acc_nxt   = 20'd0;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end
endmodule
